// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream (word count, then words)
// into BRAM writes and holds the core in reset until the load completes.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 2;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t              state, state_n;
    logic [IDX_W-1:0]    byte_idx, byte_idx_n;
    logic [WORD_W-1:0]   shreg, shreg_n;
    logic [WORD_W-1:0]   n_words, n_words_n;
    logic [WORD_W-1:0]   word_idx, word_idx_n;
    logic [WORD_W-1:0]   asm_word;
    logic                acc;
    logic                last_byte;
    state_t              end_state;

    logic                rx_ready_n, mem_we_n, core_rst_n, done_n, err_n;
    logic [WORD_W-1:0]   mem_addr_n, mem_di_n;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          xor_acc, xor_acc_n;
`endif

    assign acc       = rx_valid && rx_ready;
    assign last_byte = acc && (byte_idx == IDX_W'(3));

`ifdef LOADER_CHECKSUM_EN
    assign end_state = S_CSUM;
`else
    assign end_state = S_DONE;
`endif

    // Current byte dropped into its lane of the partially assembled word
    always_comb begin
        asm_word = shreg;
        case (byte_idx)
            2'd0:    asm_word[7:0]   = rx_data;
            2'd1:    asm_word[15:8]  = rx_data;
            2'd2:    asm_word[23:16] = rx_data;
            default: asm_word[31:24] = rx_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HDR;
            byte_idx <= '0;
            shreg    <= '0;
            n_words  <= '0;
            word_idx <= '0;
            rx_ready <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
            mem_di   <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            shreg    <= shreg_n;
            n_words  <= n_words_n;
            word_idx <= word_idx_n;
            rx_ready <= rx_ready_n;
            mem_en   <= mem_we_n;
            mem_we   <= mem_we_n;
            mem_addr <= mem_addr_n;
            mem_di   <= mem_di_n;
            core_rst <= core_rst_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) xor_acc <= '0;
        else     xor_acc <= xor_acc_n;
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        shreg_n    = shreg;
        n_words_n  = n_words;
        word_idx_n = word_idx;
        mem_we_n   = 1'b0;
        mem_addr_n = mem_addr;
        mem_di_n   = mem_di;
`ifdef LOADER_CHECKSUM_EN
        xor_acc_n  = acc ? (xor_acc ^ rx_data) : xor_acc;
`endif

        if (acc && (state == S_HDR || state == S_DATA)) begin
            byte_idx_n = byte_idx + IDX_W'(1);
            shreg_n    = asm_word;
        end

        case (state)
            S_HDR: begin
                if (last_byte) begin
                    if (asm_word > WORD_W'(MAX_WORDS)) begin
                        state_n = S_ERR;
                    end else if (asm_word == '0) begin
                        state_n = end_state;
                    end else begin
                        state_n    = S_DATA;
                        n_words_n  = asm_word;
                        word_idx_n = '0;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    mem_we_n   = 1'b1;
                    mem_di_n   = asm_word;
                    mem_addr_n = BASE_ADDR + {word_idx[WORD_W-3:0], 2'b00};
                    word_idx_n = word_idx + WORD_W'(1);
                    if (word_idx + WORD_W'(1) == n_words) state_n = end_state;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (acc) state_n = (rx_data == xor_acc) ? S_DONE : S_ERR;
            end
`endif
            default: state_n = state;
        endcase

        rx_ready_n = (state_n != S_DONE) && (state_n != S_ERR);
        core_rst_n = (state != S_DONE);
        done_n     = (state == S_DONE);
        err_n      = (state_n == S_ERR);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; BRAM writes are logged at negedge.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_di;
    logic        core_rst, done, err;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_total = 0;

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    // Write log; each one-cycle pulse is seen at exactly one negedge
    always @(negedge clk) begin
        if (mem_we || mem_en) begin
            total++;
            if (mem_en !== mem_we) begin
                bad++;
                $display("FAIL mem_en_eq_we: mem_en=%b mem_we=%b", mem_en, mem_we);
            end
            if (wr_total < 64) begin
                wr_addr[wr_total] = mem_addr;
                wr_data[wr_total] = mem_di;
            end
            wr_total++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one byte; bounded wait for rx_ready
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            if (rx_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_byte_timeout: byte=%h rx_ready=%b required 1", b, rx_ready);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'hA5;
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        send_byte(b);
`else
        if (b == 8'hFF) $display("checksum byte unused: %h", b);
`endif
    endtask

    // After the final stream byte: done/core_rst change exactly one edge later
    task automatic check_done_timing(input string name);
        @(negedge clk);
        rx_valid = 1'b0;
        total++;
        if (done !== 1'b0 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL %s_early: done=%b core_rst=%b required 0/1", name, done, core_rst);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || core_rst !== 1'b0 || err !== 1'b0 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: done=%b core_rst=%b err=%b rx_ready=%b required 1/0/0/0",
                     name, done, core_rst, err, rx_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rx_ready !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
            mem_di !== 32'h0 || core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b en=%b we=%b addr=%h di=%h crst=%b done=%b err=%b",
                     rx_ready, mem_en, mem_we, mem_addr, mem_di, core_rst, done, err);
        end
        rx_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rx_ready !== 1'b1 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: rx_ready=%b core_rst=%b required 1/1", rx_ready, core_rst);
        end
    endtask

    task automatic test_two_words();
        int base;
        logic [7:0] s [0:11];
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
        do_reset();
        base = wr_total;
        for (int i = 0; i < 12; i++) send_byte(s[i]);
        send_csum(8'hB2);
        check_done_timing("two_words");
        total++;
        if (wr_total - base !== 2) begin
            bad++;
            $display("FAIL two_words_count: writes=%0d required 2", wr_total - base);
        end else begin
            total++;
            if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h0010_0013) begin
                bad++;
                $display("FAIL two_words_w0: addr=%h data=%h required 0/00100013",
                         wr_addr[base], wr_data[base]);
            end
            total++;
            if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h0020_0093) begin
                bad++;
                $display("FAIL two_words_w1: addr=%h data=%h required 4/00200093",
                         wr_addr[base+1], wr_data[base+1]);
            end
        end
    endtask

    task automatic test_zero_count();
        int base;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_csum(8'h00);
        check_done_timing("zero_count");
        repeat (3) @(negedge clk);
        total++;
        if (wr_total - base !== 0 || done !== 1'b1) begin
            bad++;
            $display("FAIL zero_count_nowrite: writes=%0d done=%b required 0/1", wr_total - base, done);
        end
    endtask

    task automatic test_count_limit();
        int base;
        // N = 1024 is accepted
        do_reset();
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
        idle();
        total++;
        if (err !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL limit_1024: err=%b rx_ready=%b required 0/1", err, rx_ready);
        end
        // N = 1025 aborts
        do_reset();
        base = wr_total;
        send_byte(8'h01); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk);
        total++;
        if (err !== 1'b1 || rx_ready !== 1'b0 || core_rst !== 1'b1) begin
            bad++;
            $display("FAIL limit_1025: err=%b rx_ready=%b core_rst=%b required 1/0/1",
                     err, rx_ready, core_rst);
        end
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'(i * 17); rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        total++;
        if (err !== 1'b1 || done !== 1'b0 || core_rst !== 1'b1 || wr_total - base !== 0) begin
            bad++;
            $display("FAIL err_sticky: err=%b done=%b core_rst=%b writes=%0d required 1/0/1/0",
                     err, done, core_rst, wr_total - base);
        end
    endtask

    task automatic test_gaps();
        int base;
        logic [7:0] s [0:7];
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        base = wr_total;
        for (int i = 0; i < 8; i++) begin
            send_byte(s[i]);
            if (i != 7) idle();
        end
        send_csum(8'h23);
        check_done_timing("gaps");
        total++;
        if (wr_total - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL gaps_write: writes=%0d addr=%h data=%h required 1/0/deadbeef",
                     wr_total - base, wr_addr[base], wr_data[base]);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        logic [7:0] s [0:7];
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'h77); send_byte(8'h66);
        do_reset();
        @(negedge clk);
        total++;
        if (core_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: core_rst=%b done=%b err=%b we=%b required 1/0/0/0",
                     core_rst, done, err, mem_we);
        end
        base = wr_total;
        for (int i = 0; i < 8; i++) send_byte(s[i]);
        send_csum(8'h45);
        check_done_timing("restart");
        total++;
        if (wr_total - base !== 1 || wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h1122_3344) begin
            bad++;
            $display("FAIL restart_write: writes=%0d addr=%h data=%h required 1/0/11223344",
                     wr_total - base, wr_addr[base], wr_data[base]);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] s [0:7];
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(s[i]);
        send_byte(8'h05);
        check_done_timing("csum_good");
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(s[i]);
        send_byte(8'h06);
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        total++;
        if (err !== 1'b1 || core_rst !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL csum_bad: err=%b core_rst=%b done=%b required 1/1/0", err, core_rst, done);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_two_words();
        test_zero_count();
        test_count_limit();
        test_gaps();
        test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
